// File: rtl/nv_nvdla_mcif_read_ig_pkg.sv
// Shared definitions for the MCIF read ingress path: source count, payload and
// weight widths, and the bpt2arb request field layout used by bpt, pipe and arb.
package nv_nvdla_mcif_read_ig_pkg;

    localparam int NUM_SRC = 4;
    localparam int PD_W    = 75;
    localparam int WT_W    = 8;
    localparam int SRC_W   = $clog2(NUM_SRC);

    // Request payload field offsets (bpt2arb format)
    localparam int REQ_ADDR_LSB    = 0;
    localparam int REQ_ADDR_W      = 64;
    localparam int REQ_SIZE_LSB    = 64;
    localparam int REQ_SIZE_W      = 3;
    localparam int REQ_SWIZZLE_BIT = 67;
    localparam int REQ_ODD_BIT     = 68;
    localparam int REQ_LTRAN_BIT   = 69;
    localparam int REQ_FTRAN_BIT   = 70;
    localparam int REQ_AXID_LSB    = 71;
    localparam int REQ_AXID_W      = 4;

    typedef struct packed {
        logic [REQ_AXID_W-1:0] axid;
        logic                  ftran;
        logic                  ltran;
        logic                  odd;
        logic                  swizzle;
        logic [REQ_SIZE_W-1:0] size;
        logic [REQ_ADDR_W-1:0] addr;
    } rd_req_t;

endpackage

// File: rtl/nv_nvdla_mcif_read_ig_wrr_arb_if.sv
// Handshake bundle around the read ingress arbiter: the per-source request
// pipes on one side and the registered request toward split/NOC on the other.
interface nv_nvdla_mcif_read_ig_wrr_arb_if #(
    parameter int NUM_SRC = nv_nvdla_mcif_read_ig_pkg::NUM_SRC,
    parameter int PD_W    = nv_nvdla_mcif_read_ig_pkg::PD_W
) ();
    import nv_nvdla_mcif_read_ig_pkg::*;

    localparam int SRC_W = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0]      arb_src_vld;
    logic [NUM_SRC*PD_W-1:0] arb_src_pd;
    logic [NUM_SRC-1:0]      arb_src_rdy;
    logic                    arb2spt_req_valid;
    logic                    arb2spt_req_ready;
    logic [PD_W-1:0]         arb2spt_req_pd;
    logic [SRC_W-1:0]        arb2spt_req_src;

    // Arbiter side: consumes source pipes, produces the output request
    modport master (
        input  arb_src_vld,
        input  arb_src_pd,
        output arb_src_rdy,
        output arb2spt_req_valid,
        input  arb2spt_req_ready,
        output arb2spt_req_pd,
        output arb2spt_req_src
    );

    // Environment side: sources and downstream consumer
    modport slave (
        output arb_src_vld,
        output arb_src_pd,
        input  arb_src_rdy,
        input  arb2spt_req_valid,
        output arb2spt_req_ready,
        input  arb2spt_req_pd,
        input  arb2spt_req_src
    );

endinterface

// File: rtl/nv_nvdla_mcif_read_rr_pick.sv
// Combinational round-robin picker: first requester after last_gnt, wrapping.
// The request vector is doubled with the lower copy masked to positions after
// last_gnt, so a single find-first over 2*NUM_SRC bits yields the winner.
module nv_nvdla_mcif_read_rr_pick #(
    parameter int NUM_SRC = nv_nvdla_mcif_read_ig_pkg::NUM_SRC,
    parameter int SRC_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SRC_W-1:0]   last_gnt,
    output logic [NUM_SRC-1:0] gnt,
    output logic [SRC_W-1:0]   gnt_idx,
    output logic               gnt_any
);
    import nv_nvdla_mcif_read_ig_pkg::*;

    localparam int POS_W = $clog2(2 * NUM_SRC);

    logic [NUM_SRC-1:0]   mask_s;
    logic [2*NUM_SRC-1:0] dbl_s;
    logic [POS_W-1:0]     pos_s;
    logic                 found_s;

    // Build the doubled vector; lower half only keeps sources after last_gnt
    always_comb begin
        mask_s = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            mask_s[i] = (i > int'(last_gnt));
        end
        dbl_s = {req, req & mask_s};
    end

    // Find the lowest set bit of the doubled vector
    always_comb begin
        pos_s   = '0;
        found_s = 1'b0;
        for (int i = 2 * NUM_SRC - 1; i >= 0; i--) begin
            pos_s   = dbl_s[i] ? POS_W'(i) : pos_s;
            found_s = found_s | dbl_s[i];
        end
    end

    // Fold the position back to a source index and one-hot grant
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = found_s;
        if (pos_s >= POS_W'(NUM_SRC)) begin
            gnt_idx = SRC_W'(pos_s - POS_W'(NUM_SRC));
        end else begin
            gnt_idx = SRC_W'(pos_s);
        end
        if (found_s) begin
            gnt[gnt_idx] = 1'b1;
        end else begin
            gnt = '0;
        end
    end

endmodule

// File: rtl/nv_nvdla_mcif_read_ig_wrr_arb.sv
// Weighted round-robin arbiter on the MCIF read ingress path. Each source holds
// a credit counter; exhausted sources yield until every valid source is out of
// credit, at which point all counters reload from the programmed weights in the
// same cycle as the arbitration. The winner is registered toward split/NOC.
module nv_nvdla_mcif_read_ig_wrr_arb #(
    parameter int NUM_SRC = nv_nvdla_mcif_read_ig_pkg::NUM_SRC,
    parameter int PD_W    = nv_nvdla_mcif_read_ig_pkg::PD_W,
    parameter int WT_W    = nv_nvdla_mcif_read_ig_pkg::WT_W
) (
    input  logic                      nvdla_core_clk,
    input  logic                      nvdla_core_rstn,
    input  logic [NUM_SRC*WT_W-1:0]   reg2dp_rd_weight,
    nv_nvdla_mcif_read_ig_wrr_arb_if.master arb_if
);
    import nv_nvdla_mcif_read_ig_pkg::*;

    localparam int               SRC_W    = $clog2(NUM_SRC);
    localparam logic [SRC_W-1:0] LAST_RST = SRC_W'(NUM_SRC - 1);
    localparam logic [WT_W-1:0]  WT_ONE   = {{(WT_W-1){1'b0}}, 1'b1};

    // A zero weight still earns one grant per round so no source starves
    function automatic logic [WT_W-1:0] eff_weight(input logic [WT_W-1:0] w);
        eff_weight = (w == {WT_W{1'b0}}) ? WT_ONE : w;
    endfunction

    logic [WT_W-1:0]    credit_r     [NUM_SRC];
    logic [WT_W-1:0]    credit_use_s [NUM_SRC];
    logic [SRC_W-1:0]   last_gnt_r;
    logic               req_valid_r;
    logic [PD_W-1:0]    req_pd_r;
    logic [SRC_W-1:0]   req_src_r;

    logic               out_free_s;
    logic               any_vld_s;
    logic               reload_s;
    logic [NUM_SRC-1:0] elig_old_s;
    logic [NUM_SRC-1:0] elig_s;
    logic [NUM_SRC-1:0] gnt_s;
    logic [SRC_W-1:0]   gnt_idx_s;
    logic               gnt_any_s;
    logic [PD_W-1:0]    sel_pd_s;

    // Slot availability and whether the current round is exhausted
    always_comb begin
        elig_old_s = '0;
        out_free_s = !req_valid_r || arb_if.arb2spt_req_ready;
        any_vld_s  = |arb_if.arb_src_vld;
        for (int i = 0; i < NUM_SRC; i++) begin
            elig_old_s[i] = arb_if.arb_src_vld[i] && (credit_r[i] != {WT_W{1'b0}});
        end
        reload_s = out_free_s && any_vld_s && (elig_old_s == {NUM_SRC{1'b0}});
    end

    // Credits seen by this cycle's pick: reloaded values on a round boundary
    always_comb begin
        elig_s = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            credit_use_s[i] = credit_r[i];
            if (reload_s) begin
                credit_use_s[i] = eff_weight(reg2dp_rd_weight[i*WT_W +: WT_W]);
            end else begin
                credit_use_s[i] = credit_r[i];
            end
            elig_s[i] = out_free_s && arb_if.arb_src_vld[i]
                        && (credit_use_s[i] != {WT_W{1'b0}});
        end
    end

    nv_nvdla_mcif_read_rr_pick #(
        .NUM_SRC (NUM_SRC),
        .SRC_W   (SRC_W)
    ) u_pick (
        .req      (elig_s),
        .last_gnt (last_gnt_r),
        .gnt      (gnt_s),
        .gnt_idx  (gnt_idx_s),
        .gnt_any  (gnt_any_s)
    );

    // Payload of the granted source
    always_comb begin
        sel_pd_s = arb_if.arb_src_pd[int'(gnt_idx_s)*PD_W +: PD_W];
    end

    assign arb_if.arb_src_rdy       = gnt_s;
    assign arb_if.arb2spt_req_valid = req_valid_r;
    assign arb_if.arb2spt_req_pd    = req_pd_r;
    assign arb_if.arb2spt_req_src   = req_src_r;

    // Credit counters and round-robin pointer advance only on a grant
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                credit_r[i] <= '0;
            end
            last_gnt_r <= LAST_RST;
        end else if (gnt_any_s) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (gnt_s[i]) begin
                    credit_r[i] <= credit_use_s[i] - WT_ONE;
                end else begin
                    credit_r[i] <= credit_use_s[i];
                end
            end
            last_gnt_r <= gnt_idx_s;
        end else begin
            last_gnt_r <= last_gnt_r;
        end
    end

    // Output valid and source index: reload when the slot frees, else hold
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            req_valid_r <= 1'b0;
            req_src_r   <= '0;
        end else if (out_free_s) begin
            req_valid_r <= gnt_any_s;
            if (gnt_any_s) begin
                req_src_r <= gnt_idx_s;
            end else begin
                req_src_r <= req_src_r;
            end
        end else begin
            req_valid_r <= req_valid_r;
        end
    end

    // Output payload is don't-care while invalid, so it carries no reset
    always_ff @(posedge nvdla_core_clk) begin
        if (out_free_s && gnt_any_s) begin
            req_pd_r <= sel_pd_s;
        end else begin
            req_pd_r <= req_pd_r;
        end
    end

endmodule

// File: doc/nv_nvdla_mcif_read_ig_wrr_arb.md
# nv_nvdla_mcif_read_ig_wrr_arb

Weighted round-robin arbiter on the MCIF read ingress path. It is the consumer end of the per-source `arb_srcN` valid/ready pipes: it drives each source's `arb_src_rdy`, selects one 75-bit read request per cycle, and registers it toward the split/NOC stage. Per-source weights come from register-programmed values, and a source whose credit is exhausted yields to others until a round reload.

## Interface
- `NUM_SRC`, default 4: number of requesting sources; must be at least 2.
- `PD_W`, default 75: request payload width, matching the `bpt2arb` request format.
- `WT_W`, default 8: width of each weight field.
- `nvdla_core_clk`  in  1  clock; all state updates on the posedge.
- `nvdla_core_rstn`  in  1  reset, asynchronous, active-low.
- `arb_src_vld`  in  NUM_SRC  per-source request valid.
- `arb_src_pd`  in  NUM_SRC*PD_W  per-source payload; source i occupies `[i*PD_W +: PD_W]`.
- `arb_src_rdy`  out  NUM_SRC  per-source ready; at most one bit is high in any cycle.
- `reg2dp_rd_weight`  in  NUM_SRC*WT_W  per-source weight; source i occupies `[i*WT_W +: WT_W]`; quasi-static.
- `arb2spt_req_valid`  out  1  output request valid (registered).
- `arb2spt_req_ready`  in  1  downstream ready.
- `arb2spt_req_pd`  out  PD_W  output payload (registered).
- `arb2spt_req_src`  out  clog2(NUM_SRC)  index of the source that produced the current output (registered).

## Operation
- Slot free: `out_free = !arb2spt_req_valid || arb2spt_req_ready`. Arbitration runs only when the slot is free.
- Eligible set: `E = {i : arb_src_vld[i] && credit[i] != 0}`.
- Reload: if some source is valid and E is empty, every `credit[i]` is loaded with `eff_wt[i] = (w[i]==0) ? 1 : w[i]`. The same cycle arbitrates using the reloaded values; there is no bubble.
- Pick: starting at `last_gnt+1` and wrapping modulo NUM_SRC, grant the first source in the eligible set.
- On a grant to source g:
  - `arb_src_rdy[g] = 1`.
  - The output register loads `pd[g]` and sets `src = g`.
  - `last_gnt <= g`.
  - `credit[g]` decrements. If this cycle was a reload, it becomes `eff_wt[g]-1`.
- No valid source and slot free: no grant; output valid clears if it was drained; credits are held.
- Slot occupied and stalled: all `arb_src_rdy` are 0. Output valid, payload and source index are held stable. Credits and `last_gnt` are held.
- A weight change takes effect at the next reload only. Credits are never clipped mid-round.
- Fairness: over one round with all sources continuously valid, source i wins exactly `eff_wt[i]` grants. A source that is invalid loses its remaining credit only when a reload occurs.
- Credit counters are WT_W bits wide and never underflow, because grants require `credit != 0`.

## Timing
- Reset values:
  - `arb2spt_req_valid = 0`, `arb2spt_req_src = 0`.
  - `last_gnt = NUM_SRC-1`, so source 0 has first priority.
  - All `credit = 0`, so the first arbitration reloads.
  - `arb2spt_req_pd` is not reset; it is don't-care while valid is 0.
- `arb_src_rdy` is combinational from `arb_src_vld`, credits, `last_gnt`, the output valid register and `arb2spt_req_ready`. It is 0 when no source is valid, which includes during reset because upstream pipes reset their valids.
- Latency: a request accepted in cycle t appears on `arb2spt_req_*` in cycle t+1.
- Throughput: 1 request per cycle when downstream ready stays high.
- Grant and output load coincide. When `arb2spt_req_valid && arb2spt_req_ready` and a new grant happen in the same cycle, the register replaces its contents with no idle cycle.
- Asserting reset mid-transfer drops the held output request. Credits and pointer return to their reset values immediately (asynchronous).

## Structure
- Shared package `nv_nvdla_mcif_read_ig_pkg`: `NUM_SRC`, `PD_W`, `WT_W`, the source index width and the request payload field offsets. The offsets are common with the bpt and pipe blocks.
- Sub-module `nv_nvdla_mcif_read_rr_pick`: purely combinational. Inputs are a request mask and `last_gnt`; outputs are a one-hot grant and an encoded index. It uses the double-width mask / find-first method.
- The top level holds the credit counters, the reload logic, `last_gnt` and the output register.

## Test plan
- **Reset then single source.** Weights all 1; only src2 valid with pd=0x1; ready=1. Required response: `rdy[2]` is high in cycle 0 after reset; output valid with pd=0x1 and src=2 one cycle later.
- **Equal weights, all valid, ready=1.** Grant order is 0,1,2,3,0,1… with one grant per cycle and no bubbles.
- **Weights {3,1,1,1}, all valid.** Per 6-grant round the order is 0,1,2,3,0,0. Counts per round: src0=3, others=1. Verify across 10 rounds.
- **Weight 0.** `w1=0`, all valid. Source 1 behaves as weight 1 and is never starved.
- **Backpressure.** Drive `arb2spt_req_ready=0` for 5 cycles while output is valid. Required response: all `rdy` are 0; pd and src are stable; credits are unchanged. On release, the next grant resumes with correct round-robin order.
- **Credit exhaustion with sparse sources.** src0 weight 2, others weight 4; src0 is valid alone until its credit is exhausted. Required response: a reload fires on src0's third request and src0 is granted that same cycle. Also verify that a weight rewrite mid-round is ignored until the next reload.
